// File: rtl/event_pkt_pkg.sv
// ---------------------------------------------------------------------------
// event_pkt_pkg
// Shared constants, record layout, FSM encoding and helper functions for the
// event packetizer.
// Optional feature macro: EVENT_PKT_SYNC_BYTE_EN. When it is defined, the
// serializer has a SYNC state that prefixes every packet with SYNC_BYTE.
// ---------------------------------------------------------------------------
package event_pkt_pkg;

  localparam logic [1:0] EVT_NONE  = 2'd0;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int TS_W   = 16;
  localparam int CNT_W  = 6;
  localparam int CODE_W = 2;
  localparam int REC_W  = CODE_W + CNT_W + TS_W;  // 24

  // Record layout: {code, cnt, ts}, with ts in the least significant bits.
  localparam int REC_TS_LSB   = 0;
  localparam int REC_CNT_LSB  = REC_TS_LSB + TS_W;
  localparam int REC_CODE_LSB = REC_CNT_LSB + CNT_W;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef EVENT_PKT_SYNC_BYTE_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_SYNC = 3'd4
  } pkt_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3
  } pkt_state_t;
`endif

  // Saturating increment of the spike counter.
  function automatic logic [CNT_W-1:0] sat_cnt_inc(input logic [CNT_W-1:0] cnt,
                                                   input logic             inc);
    logic [CNT_W-1:0] res;
    if (inc && (cnt != CNT_MAX)) begin
      res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  // Pack one event record.
  function automatic logic [REC_W-1:0] pack_rec(input logic [CODE_W-1:0] code,
                                                input logic [CNT_W-1:0]  cnt,
                                                input logic [TS_W-1:0]   ts);
    return {code, cnt, ts};
  endfunction

endpackage

// File: rtl/event_fifo.sv
// ---------------------------------------------------------------------------
// event_fifo
// A synchronous FIFO whose read data is registered on pop. The dout register
// holds the last popped word until the next pop, so the consumer can use it
// as a holding register.
// Ports:
//   clk, rst       clock, synchronous active-high reset (empties the FIFO)
//   push, din      write request and data (ignored when full)
//   pop, dout      read request (ignored when empty) and registered read data
//   full, empty    status, taken from the current pointers
//   level          number of stored words
// ---------------------------------------------------------------------------
module event_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s, do_pop_s;

  // Pointers carry one extra wrap bit: equal indices with differing wrap bits means full.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = dout_q;

  // Next-state computation for the pointers and the read register.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    dout_d    = dout_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      dout_d   = mem_q[rd_ptr_q[AW-1:0]];
    end else begin
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
    end
  end

  // Pointer and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      dout_q   <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset is applied.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/event_packetizer.sv
// ---------------------------------------------------------------------------
// event_packetizer
// Timestamps each new classifier event with a free-running counter and a
// saturating spike count, then buffers the record in a FIFO. It serializes
// the record as a byte stream over a valid/ready handshake:
//   {code, cnt}, ts[15:8], ts[7:0]
// Optional feature macro: EVENT_PKT_SYNC_BYTE_EN. When it is defined, 0xA5 is
// sent before the first byte of every packet.
// Ports:
//   clk, rst     clock, synchronous active-high reset (aborts any packet)
//   spike_in     spike strobe, counted per cycle
//   event_in     class code; 0 means no event
//   out_data     serialized byte, out_valid qualifies it, out_ready accepts it
//   fifo_level   records waiting (excludes the record being serialized)
//   overflow     sticky flag, set when a record is dropped because the FIFO is full
// ---------------------------------------------------------------------------
module event_packetizer
  import event_pkt_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spike_in,
  input  logic [1:0]                    event_in,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

`ifdef EVENT_PKT_SYNC_BYTE_EN
  localparam pkt_state_t FIRST_ST = ST_SYNC;
`else
  localparam pkt_state_t FIRST_ST = ST_B0;
`endif

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [CNT_W-1:0]  sc_q, sc_d;
  logic [1:0]        event_q, event_d;
  logic              overflow_q, overflow_d;
  logic              out_valid_q, out_valid_d;
  pkt_state_t        state_q, state_d;

  logic              capture_s, accept_s;
  logic [CNT_W-1:0]  rec_cnt_s;
  logic [REC_W-1:0]  rec_s, hold_rec_s;
  logic              fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;

  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

  // Capture logic: timestamp, spike counter, record build and overflow.
  always_comb begin
    ts_d       = ts_q + {{(TS_W-1){1'b0}}, 1'b1};
    event_d    = event_in;
    capture_s  = (event_in != EVT_NONE) && (event_in != event_q);
    // A spike in the capture cycle is counted into that record.
    rec_cnt_s  = sat_cnt_inc(sc_q, spike_in);
    rec_s      = pack_rec(event_in, rec_cnt_s, ts_q);
    // Fullness is taken before any same-cycle pop, so a capture while full is dropped.
    fifo_push_s = capture_s && !fifo_full_s;
    overflow_d  = overflow_q | (capture_s && fifo_full_s);
    if (capture_s) begin
      sc_d = {CNT_W{1'b0}};
    end else begin
      sc_d = rec_cnt_s;
    end
  end

  // Serializer next state; the FIFO read register is the packet holding register.
  always_comb begin
    state_d    = state_q;
    fifo_pop_s = 1'b0;
    accept_s   = out_valid_q && out_ready;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          state_d    = FIRST_ST;
        end else begin
          state_d    = ST_IDLE;
        end
      end
`ifdef EVENT_PKT_SYNC_BYTE_EN
      ST_SYNC: begin
        if (accept_s) state_d = ST_B0;
        else          state_d = ST_SYNC;
      end
`endif
      ST_B0: begin
        if (accept_s) state_d = ST_B1;
        else          state_d = ST_B0;
      end
      ST_B1: begin
        if (accept_s) state_d = ST_B2;
        else          state_d = ST_B1;
      end
      ST_B2: begin
        if (accept_s) state_d = ST_IDLE;
        else          state_d = ST_B2;
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d != ST_IDLE);
  end

  // Byte select from the held record; IDLE drives zero.
  always_comb begin
    out_data = 8'd0;
    case (state_q)
`ifdef EVENT_PKT_SYNC_BYTE_EN
      ST_SYNC: out_data = SYNC_BYTE;
`endif
      ST_B0:   out_data = {hold_rec_s[REC_CODE_LSB +: CODE_W], hold_rec_s[REC_CNT_LSB +: CNT_W]};
      ST_B1:   out_data = hold_rec_s[REC_TS_LSB + 8 +: 8];
      ST_B2:   out_data = hold_rec_s[REC_TS_LSB +: 8];
      default: out_data = 8'd0;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= {TS_W{1'b0}};
      sc_q        <= {CNT_W{1'b0}};
      event_q     <= 2'd0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      ts_q        <= ts_d;
      sc_q        <= sc_d;
      event_q     <= event_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
    end
  end

  event_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (rec_s),
    .dout  (hold_rec_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_event_packetizer.sv
// ---------------------------------------------------------------------------
// tb_event_packetizer
// Directed bench for event_packetizer. It uses a table of single-event
// packets plus hand-written sequences for the multi-cycle cases: latency,
// back-pressure, overflow, timestamp wrap and mid-packet reset. Accepted
// bytes are collected by a monitor and compared with values computed here.
// ---------------------------------------------------------------------------
module tb_event_packetizer;

`ifdef EVENT_PKT_SYNC_BYTE_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  localparam int NB = 3 + OFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spike_in = 1'b0;
  logic [1:0] event_in = 2'd0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic [3:0] fifo_level;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  logic [15:0] ts_m;
  logic [7:0]  q[$];

  typedef struct {
    logic [1:0] code;
    int         nspk;
    logic       cap_spk;
    logic [7:0] exp_b0;
  } vec_t;
  vec_t vecs[6];

  event_packetizer #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .spike_in   (spike_in),
    .event_in   (event_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference timestamp: equals the DUT counter for the cycle being driven.
  always @(posedge clk) ts_m <= rst ? 16'h0000 : ts_m + 16'h0001;

  // Byte monitor: a byte seen valid and ready here is accepted at the next rising edge.
  always @(negedge clk) if (!rst && out_valid && out_ready) q.push_back(out_data);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int k = 0;
    while (q.size() < n && k < budget) begin
      step();
      k++;
    end
    check(name, (q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_pkt(input string name, input int base, input logic [7:0] b0,
                           input logic [15:0] ts);
    logic [7:0] hi, lo;
    hi = ts[15:8];
    lo = ts[7:0];
`ifdef EVENT_PKT_SYNC_BYTE_EN
    check({name, "_sync"}, q[base], 8'hA5);
`endif
    check({name, "_b0"}, q[base+OFF], b0);
    check({name, "_b1"}, q[base+OFF+1], hi);
    check({name, "_b2"}, q[base+OFF+2], lo);
  endtask

  // Drive nspk spike cycles, then one capture cycle; returns the capture timestamp.
  task automatic capture(input logic [1:0] code, input int nspk, input logic cap_spk,
                         output logic [15:0] ts);
    for (int i = 0; i < nspk; i++) begin
      spike_in = 1'b1;
      step();
    end
    spike_in = cap_spk;
    event_in = code;
    ts = ts_m;
    step();
    event_in = 2'd0;
    spike_in = 1'b0;
  endtask

  initial begin
    logic [15:0] t0, t1, t2;
    logic [15:0] tsv[10];
    int bad;
    int k;

    vecs[0] = '{2'd2, 0,   1'b0, 8'h80};
    vecs[1] = '{2'd3, 5,   1'b1, 8'hC6};
    vecs[2] = '{2'd1, 70,  1'b0, 8'h7F};
    vecs[3] = '{2'd3, 100, 1'b0, 8'hFF};
    vecs[4] = '{2'd2, 0,   1'b0, 8'h80};
    vecs[5] = '{2'd2, 63,  1'b1, 8'hBF};

    // Reset state.
    rst = 1'b1;
    step();
    step();
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_level", fifo_level, 4'd0);
    check("rst_ovf", overflow, 1'b0);
    rst = 1'b0;

    // Test 1: code 1 at ts 0x0010 with three prior spikes, then latency.
    k = 0;
    while (ts_m != 16'h000D && k < 100) begin
      step();
      k++;
    end
    q.delete();
    capture(2'd1, 3, 1'b0, t0);
    check("t1_ts", t0, 16'h0010);
    check("t1_lat_n1", out_valid, 1'b0);
    step();
    check("t1_lat_n2", out_valid, 1'b1);
`ifdef EVENT_PKT_SYNC_BYTE_EN
    check("t1_first", out_data, 8'hA5);
`else
    check("t1_first", out_data, 8'h43);
`endif
    wait_bytes(NB, 50, "t1_timeout");
    check_pkt("t1", 0, 8'h43, 16'h0010);
    check("t1_level", fifo_level, 4'd0);

    // Table: single events with various spike histories.
    for (int i = 0; i < 6; i++) begin
      q.delete();
      capture(vecs[i].code, vecs[i].nspk, vecs[i].cap_spk, t0);
      wait_bytes(NB, 50, $sformatf("vec%0d_timeout", i));
      check_pkt($sformatf("vec%0d", i), 0, vecs[i].exp_b0, t0);
    end

    // Test 2: held code gives one record; re-asserting after 0 gives another.
    q.delete();
    event_in = 2'd2;
    t0 = ts_m;
    for (int i = 0; i < 20; i++) step();
    event_in = 2'd0;
    step();
    event_in = 2'd2;
    t1 = ts_m;
    step();
    event_in = 2'd0;
    wait_bytes(2 * NB, 100, "t2_timeout");
    for (int i = 0; i < 20; i++) step();
    check("t2_count", q.size(), 2 * NB);
    check_pkt("t2_r0", 0, 8'h80, t0);
    check_pkt("t2_r1", NB, 8'h80, t1);

    // Test 3: back-pressure holds the first byte stable.
    q.delete();
    out_ready = 1'b0;
    capture(2'd1, 0, 1'b0, t0);
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    check("t3_valid", out_valid, 1'b1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
`ifdef EVENT_PKT_SYNC_BYTE_EN
      if (out_valid !== 1'b1 || out_data !== 8'hA5) bad++;
`else
      if (out_valid !== 1'b1 || out_data !== 8'h40) bad++;
`endif
      step();
    end
    check("t3_stable", bad, 0);
    out_ready = 1'b1;
    wait_bytes(NB, 50, "t3_timeout");
    check_pkt("t3", 0, 8'h40, t0);

    // Test 4: ten back-to-back events under back-pressure overflow the FIFO.
    q.delete();
    out_ready = 1'b0;
    check("t4_ovf_pre", overflow, 1'b0);
    for (int i = 0; i < 10; i++) begin
      event_in = (i % 2 == 0) ? 2'd1 : 2'd2;
      tsv[i] = ts_m;
      step();
    end
    event_in = 2'd0;
    step();
    step();
    check("t4_level", fifo_level, 4'd8);
    check("t4_ovf", overflow, 1'b1);
    out_ready = 1'b1;
    wait_bytes(9 * NB, 400, "t4_timeout");
    for (int i = 0; i < 9; i++) begin
      check_pkt($sformatf("t4_r%0d", i), i * NB, (i % 2 == 0) ? 8'h40 : 8'h80, tsv[i]);
    end
    for (int i = 0; i < 20; i++) step();
    check("t4_count", q.size(), 9 * NB);
    check("t4_level_end", fifo_level, 4'd0);

    // Test 6: timestamp wrap between two back-to-back captures.
    k = 0;
    while (ts_m != 16'hFFFF && k < 70000) begin
      step();
      k++;
    end
    q.delete();
    event_in = 2'd1;
    t0 = ts_m;
    step();
    event_in = 2'd2;
    t1 = ts_m;
    step();
    event_in = 2'd0;
    check("t6_ts0", t0, 16'hFFFF);
    check("t6_ts1", t1, 16'h0000);
    wait_bytes(2 * NB, 100, "t6_timeout");
    check_pkt("t6_r0", 0, 8'h40, 16'hFFFF);
    check_pkt("t6_r1", NB, 8'h80, 16'h0000);

    // Reset in the middle of byte1 aborts the packet and empties the FIFO.
    q.delete();
    out_ready = 1'b0;
    capture(2'd1, 0, 1'b0, t2);
    event_in = 2'd2;
    step();
    event_in = 2'd1;
    step();
    event_in = 2'd0;
    step();
    step();
    check("t6_level_pre", fifo_level, 4'd2);
    out_ready = 1'b1;
    k = 0;
    while (q.size() < OFF + 1 && k < 20) begin
      step();
      k++;
    end
    check("t6_in_b1", out_data, {24'd0, t2[15:8]});
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_level", fifo_level, 4'd0);
    check("t6_rst_ovf", overflow, 1'b0);
    check("t6_rst_data", out_data, 8'h00);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("t6_no_resume", q.size(), OFF + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
